image_loader: RTL and testbench



---
 rtl/cnn_pkg.sv | 18 +
 rtl/image_loader_if.sv | 13 +
 rtl/image_buffer.sv | 31 +++
 rtl/image_loader.sv | 120 ++++++++++++
 tb/tb_image_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath parameters and the image loader state type.
package cnn_pkg;

    localparam int unsigned DATA_SIZE  = 16;
    localparam int unsigned ADDR_WIDTH = 20;
    localparam int unsigned N_MAX      = 32;
    localparam int unsigned SIZE_WIDTH = 16;
    localparam int unsigned N_WORDS    = N_MAX * N_MAX;
    localparam int unsigned IDX_WIDTH  = $clog2(N_WORDS);
    localparam int unsigned CNT_WIDTH  = $clog2(N_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

    function automatic logic size_legal(input logic [SIZE_WIDTH-1:0] s);
        return (s != '0) && (s <= SIZE_WIDTH'(N_MAX));
    endfunction

endpackage

// File: rtl/image_loader_if.sv
// Memory read bus between the image loader (master) and intermediate-layer memory (slave).
interface image_loader_if;
    import cnn_pkg::*;

    logic                  memRead;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_SIZE-1:0]  memData;
    logic                  memAck;

    modport master (output memRead, output memAddr, input memData, input memAck);
    modport slave  (input memRead, input memAddr, output memData, output memAck);

endinterface

// File: rtl/image_buffer.sv
// N_MAX x N_MAX pixel register array: one write port, synchronous full clear, flat read-out.
module image_buffer
    import cnn_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         clr_i,
    input  logic                         we_i,
    input  logic [IDX_WIDTH-1:0]         idx_i,
    input  logic [DATA_SIZE-1:0]         data_i,
    output logic [N_WORDS*DATA_SIZE-1:0] image_o
);

    logic [N_WORDS*DATA_SIZE-1:0] mem_q, mem_d;

    // Clear wins over a write in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (clr_i) begin
            mem_d = '0;
        end else if (we_i) begin
            mem_d[idx_i*DATA_SIZE +: DATA_SIZE] = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign image_o = mem_q;

endmodule

// File: rtl/image_loader.sv
// Loads an S x S feature map from memory into a flattened N_MAX x N_MAX buffer.
// Optional: define IMAGE_LOADER_ZERO_PAD_EN to clear the buffer on each accepted legal start.
module image_loader
    import cnn_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        baseAddr,
    input  logic [SIZE_WIDTH-1:0]        imgSize,
    image_loader_if.master               mem,
    output logic [N_WORDS*DATA_SIZE-1:0] image,
    output logic                         busy,
    output logic                         done,
    output logic                         sizeErr
);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic [CNT_WIDTH-1:0]  col_q, col_d;
    logic                  size_err_q, size_err_d;

    logic                  buf_we;
    logic                  buf_clr;
    logic [IDX_WIDTH-1:0]  buf_idx;
    logic                  last_col;
    logic                  last_row;

    assign last_col = (SIZE_WIDTH'(col_q) == size_q - SIZE_WIDTH'(1));
    assign last_row = (SIZE_WIDTH'(row_q) == size_q - SIZE_WIDTH'(1));
    assign buf_idx  = IDX_WIDTH'(32'(row_q) * N_MAX + 32'(col_q));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        row_d      = row_q;
        col_d      = col_q;
        size_err_d = size_err_q;
        buf_we     = 1'b0;
        buf_clr    = reset;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = baseAddr;
                    size_d     = imgSize;
                    row_d      = '0;
                    col_d      = '0;
                    size_err_d = !size_legal(imgSize);
                    if (size_legal(imgSize)) begin
                        state_d = LOAD;
`ifdef IMAGE_LOADER_ZERO_PAD_EN
                        buf_clr = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (mem.memAck) begin
                    buf_we = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + CNT_WIDTH'(1);
                        if (last_row) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + CNT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            row_q      <= row_d;
            col_q      <= col_d;
            size_err_q <= size_err_d;
        end
    end

    assign mem.memRead = (state_q == LOAD);
    assign mem.memAddr = addr_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign sizeErr     = size_err_q;

    image_buffer u_image_buffer (
        .clk_i   (clk),
        .clr_i   (buf_clr),
        .we_i    (buf_we),
        .idx_i   (buf_idx),
        .data_i  (mem.memData),
        .image_o (image)
    );

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: expected transfers queued at start, popped on each ack.
module tb_image_loader;
    import cnn_pkg::*;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        int                    idx;
    } xfer_t;

    logic                         clk;
    logic                         reset;
    logic                         start;
    logic [ADDR_WIDTH-1:0]        base_addr;
    logic [SIZE_WIDTH-1:0]        img_size;
    logic [N_WORDS*DATA_SIZE-1:0] image;
    logic                         busy;
    logic                         done;
    logic                         size_err;
    logic                         fill_ones;

    xfer_t          sb_q[$];
    logic [15:0]    img_m [N_WORDS];
    int             n_checks;
    int             n_errs;

    image_loader_if bus ();

    assign bus.memData = fill_ones ? 16'hFFFF : bus.memAddr[15:0];

    image_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .baseAddr (base_addr),
        .imgSize  (img_size),
        .mem      (bus.master),
        .image    (image),
        .busy     (busy),
        .done     (done),
        .sizeErr  (size_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < int'(N_WORDS); i++) begin
            check_val($sformatf("%s[%0d]", tag, i), 32'(image[i*DATA_SIZE +: DATA_SIZE]),
                      32'(img_m[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(N_WORDS); i++) img_m[i] = 16'h0;
    endtask

    task automatic push_xfers(input logic [ADDR_WIDTH-1:0] base, input int s);
        for (int k = 0; k < s * s; k++) begin
            xfer_t x;
            x.addr = base + ADDR_WIDTH'(k);
            x.idx  = (k / s) * 32 + (k % s);
            sb_q.push_back(x);
        end
    endtask

    // Compare the head of the scoreboard against the bus; pop it if this cycle is a transfer.
    task automatic observe_read(input string tag, input logic ack);
        xfer_t x;
        if (sb_q.size() == 0) begin
            check_val({tag, "_spurious_read"}, 32'(bus.memRead), 32'(0));
        end else begin
            check_val({tag, "_addr"}, 32'(bus.memAddr), 32'(sb_q[0].addr));
            if (ack) begin
                x = sb_q.pop_front();
                img_m[x.idx] = fill_ones ? 16'hFFFF : x.addr[15:0];
            end
        end
    endtask

    task automatic run_load(input string tag, input logic [ADDR_WIDTH-1:0] base,
                            input logic [15:0] s, input int period, input logic ones,
                            input logic exp_err);
        int   cyc;
        int   done_cyc;
        int   last_ack;
        logic legal;
        logic ack;
        legal     = (s != 16'd0) && (s <= 16'd32);
        fill_ones = ones;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        img_size  = s;
        if (legal) begin
`ifdef IMAGE_LOADER_ZERO_PAD_EN
            clear_model();
`endif
            push_xfers(base, int'(s));
        end
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        last_ack = 0;
        while (cyc < 4000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            ack        = (cyc % period) == 0;
            bus.memAck = ack;
            if (bus.memRead) begin
                observe_read(tag, ack);
                if (ack) last_ack = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        bus.memAck = 1'b0;
        if (done_cyc < 0) begin
            check_val({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check_val({tag, "_done_after_ack"}, 32'(done_cyc),
                      legal ? 32'(last_ack + 1) : 32'(1));
            if (legal && period == 1) begin
                check_val({tag, "_done_cycle"}, 32'(done_cyc), 32'(int'(s) * int'(s) + 1));
            end
            check_val({tag, "_read_in_done"}, 32'(bus.memRead), 32'(0));
            check_val({tag, "_busy_in_done"}, 32'(busy), 32'(1));
            check_val({tag, "_size_err"}, 32'(size_err), 32'(exp_err));
            check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'(0));
            check_image({tag, "_pix"});
        end
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(done), 32'(0));
        check_val({tag, "_busy_idle"}, 32'(busy), 32'(0));
        check_val({tag, "_size_err_held"}, 32'(size_err), 32'(exp_err));
    endtask

    initial begin
        n_checks   = 0;
        n_errs     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        img_size   = '0;
        fill_ones  = 1'b0;
        bus.memAck = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_val("rst_read", 32'(bus.memRead), 32'(0));
        check_val("rst_addr", 32'(bus.memAddr), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_size_err", 32'(size_err), 32'(0));
        check_image("rst_pix");
        reset = 1'b0;

        run_load("s4", 20'h00100, 16'd4, 1, 1'b0, 1'b0);
        run_load("s3_wait", 20'h00300, 16'd3, 3, 1'b0, 1'b0);
        run_load("s0", 20'h00400, 16'd0, 1, 1'b0, 1'b1);
        run_load("s33", 20'h00500, 16'd33, 1, 1'b0, 1'b1);
        run_load("wrap", 20'hFFFFE, 16'd2, 1, 1'b0, 1'b0);

        // Reset mid-load, with an extra start pulsed while loading.
        fill_ones = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 20'h00200;
        img_size  = 16'd4;
        push_xfers(20'h00200, 4);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.memAck = 1'b1;
            check_val("mid_read", 32'(bus.memRead), 32'(1));
            observe_read("mid", 1'b1);
            @(negedge clk);
        end
        start      = 1'b1;
        base_addr  = 20'h07000;
        img_size   = 16'd2;
        bus.memAck = 1'b1;
        observe_read("mid_start", 1'b1);
        @(negedge clk);
        start = 1'b0;
        check_val("mid_still_busy", 32'(busy), 32'(1));
        check_val("mid_still_read", 32'(bus.memRead), 32'(1));
        observe_read("mid_after_start", 1'b0);
        bus.memAck = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        clear_model();
        check_val("mrst_read", 32'(bus.memRead), 32'(0));
        check_val("mrst_addr", 32'(bus.memAddr), 32'(0));
        check_val("mrst_busy", 32'(busy), 32'(0));
        check_val("mrst_done", 32'(done), 32'(0));
        check_val("mrst_size_err", 32'(size_err), 32'(0));
        check_image("mrst_pix");
        repeat (3) begin
            @(negedge clk);
            check_val("start_not_queued", 32'(bus.memRead), 32'(0));
        end

        // Stale data outside S x S depends on the zero-pad build option.
        run_load("fill", 20'h00600, 16'd4, 1, 1'b1, 1'b0);
        run_load("small", 20'h00700, 16'd2, 1, 1'b0, 1'b0);
`ifdef IMAGE_LOADER_ZERO_PAD_EN
        check_val("pix_3_3", 32'(image[(3*32+3)*DATA_SIZE +: DATA_SIZE]), 32'h0000);
`else
        check_val("pix_3_3", 32'(image[(3*32+3)*DATA_SIZE +: DATA_SIZE]), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
